mul_share_arbiter: RTL and testbench

MUL_SHARE_ARBITER -- requirements
Module: mul_share_arbiter

---
 rtl/mul_share_arbiter.sv | 116 +++++++++++
 tb/tb_mul_share_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter.sv
// Two-requester round-robin front end sharing one shift-add multiplier.
// Each accepted operand pair is multiplied over WIDTH cycles. The product
// is then held in a response slot until the consumer takes it.
module mul_share_arbiter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               req1_ready,
  output logic               rsp_valid,
  output logic               rsp_id,
  output logic [2*WIDTH-1:0] rsp_result,
  input  logic               rsp_ready,
  output logic               busy
);

  localparam int unsigned RW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic              ptr;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic              op_id;
  logic [RW-1:0]     acc;
  logic [CW-1:0]     cnt;

  logic              grant1;
  logic [RW-1:0]     partial;
  logic [RW-1:0]     acc_next;

  // Arbitration: the pointer only matters when both requesters are valid.
  always_comb begin
    grant1     = req1_valid && (!req0_valid || ptr);
    req0_ready = (state == IDLE) && req0_valid && !grant1;
    req1_ready = (state == IDLE) && grant1;
  end

  // One shift-add step: add a shifted copy of a when the current bit of b is set.
  always_comb begin
    partial  = '0;
    if (op_b[cnt]) begin
      partial = RW'(op_a) << cnt;
    end
    acc_next = acc + partial;
  end

  // Control FSM with the shared datapath and registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      op_id      <= 1'b0;
      acc        <= '0;
      cnt        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            op_a  <= req1_ready ? req1_a : req0_a;
            op_b  <= req1_ready ? req1_b : req0_b;
            op_id <= req1_ready;
            ptr   <= !req1_ready;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= MUL;
          end
        end
        MUL: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            rsp_valid  <= 1'b1;
            rsp_result <= acc_next;
            rsp_id     <= op_id;
            state      <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: directed scenarios with literal expectations,
// then random traffic checked every cycle against a transaction-level model.
module tb_mul_share_arbiter;

  localparam int unsigned W  = 4;
  localparam int unsigned RW = 2 * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic          req0_ready, req1_ready;
  logic          rsp_valid, rsp_id, rsp_ready, busy;
  logic [RW-1:0] rsp_result;

  always #5 clk = ~clk;

  mul_share_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_ready  (rsp_ready),
    .busy       (busy)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Transaction-level model: at most one job in flight; its product is a*b
  // and it becomes visible W+1 cycles after the accepting cycle.
  int            cyc    = 0;
  bit            armed  = 1'b0;
  bit            m_busy = 1'b0;
  bit            m_ptr  = 1'b0;
  bit            m_id   = 1'b0;
  int            m_due  = 0;
  logic [RW-1:0] m_prod = '0;
  logic [RW-1:0] m_last = '0;
  bit            e0, e1, in_resp;

  always @(negedge clk) begin
    cyc++;
    e0      = !m_busy && req0_valid && (!req1_valid || !m_ptr);
    e1      = !m_busy && req1_valid && (!req0_valid || m_ptr);
    in_resp = m_busy && (cyc >= m_due);
    if (armed) begin
      check("m_ready0", 64'(req0_ready), 64'(e0));
      check("m_ready1", 64'(req1_ready), 64'(e1));
      check("m_busy",   64'(busy),       64'(m_busy));
      check("m_rvalid", 64'(rsp_valid),  64'(in_resp));
      if (in_resp) begin
        check("m_rid",  64'(rsp_id),     64'(m_id));
        check("m_rres", 64'(rsp_result), 64'(m_prod));
      end else if (!m_busy) begin
        check("m_hold", 64'(rsp_result), 64'(m_last));
      end
    end
    if (rst) begin
      m_busy = 1'b0;
      m_ptr  = 1'b0;
      m_last = '0;
      armed  = 1'b1;
    end else if (armed) begin
      if (in_resp && rsp_ready) begin
        m_busy = 1'b0;
        m_last = m_prod;
      end else if (e0 || e1) begin
        m_id   = e1;
        m_prod = RW'(e1 ? req1_a : req0_a) * RW'(e1 ? req1_b : req0_b);
        m_due  = cyc + int'(W) + 1;
        m_busy = 1'b1;
        m_ptr  = !e1;
      end
    end
  end

  task automatic reset_dut();
    @(posedge clk); #1;
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_hs(input bit which);
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (which ? (req1_valid && req1_ready) : (req0_valid && req0_ready)) ok = 1'b1;
    end
    check("hs_seen", 64'(ok), 64'd1);
  endtask

  // Latency counts negedges from the call; call it right after the posedge
  // that follows the handshake cycle.
  task automatic wait_rsp(output logic id, output logic [RW-1:0] res, output int lat);
    bit seen = 1'b0;
    bit done = 1'b0;
    int n = 0;
    lat = -1; id = 1'b0; res = '0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
      if (rsp_valid && !seen) begin
        seen = 1'b1; lat = n; id = rsp_id; res = rsp_result;
      end
      if (rsp_valid && rsp_ready) done = 1'b1;
    end
    check("rsp_seen", 64'(done), 64'd1);
  endtask

  task automatic single(input bit which, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [RW-1:0] exp, input string tag);
    logic          id;
    logic [RW-1:0] res;
    int            lat;
    @(posedge clk); #1;
    if (which) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else       begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    wait_hs(which);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rsp(id, res, lat);
    check({tag, "_lat"}, 64'(lat), 64'(W + 1));
    check({tag, "_id"},  64'(id),  64'(which));
    check({tag, "_res"}, 64'(res), 64'(exp));
  endtask

  initial begin
    logic          id;
    logic [RW-1:0] res;
    int            lat;
    int            hs_cyc[$];
    int            lc;

    rst = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_rvalid", 64'(rsp_valid),  64'd0);
    check("rst_busy",   64'(busy),       64'd0);
    check("rst_result", 64'(rsp_result), 64'd0);
    check("rst_id",     64'(rsp_id),     64'd0);
    check("rst_ready0", 64'(req0_ready), 64'd0);

    // Single request 15*15
    single(1'b0, 4'd15, 4'd15, 8'd225, "single");

    // Zero operands keep full latency
    single(1'b0, 4'd0, 4'd12, 8'd0, "zero_a");
    single(1'b1, 4'd9, 4'd0,  8'd0, "zero_b");

    // Simultaneous requests alternate, starting at requester 0
    reset_dut();
    req0_a = 4'd3; req0_b = 4'd5; req1_a = 4'd7; req1_b = 4'd9;
    req0_valid = 1'b1; req1_valid = 1'b1;
    wait_rsp(id, res, lat);
    check("rr1_id", 64'(id), 64'd0); check("rr1_res", 64'(res), 64'd15);
    wait_rsp(id, res, lat);
    check("rr2_id", 64'(id), 64'd1); check("rr2_res", 64'(res), 64'd63);
    wait_rsp(id, res, lat);
    check("rr3_id", 64'(id), 64'd0); check("rr3_res", 64'(res), 64'd15);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Back-pressure holds the response and blocks new grants
    reset_dut();
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd3;
    wait_hs(1'b0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'd6;
    lc = 0;
    do begin @(negedge clk); lc++; end while (!rsp_valid && lc < 30);
    for (int i = 0; i < 10; i++) begin
      check("bp_res",    64'(rsp_result), 64'd6);
      check("bp_id",     64'(rsp_id),     64'd0);
      check("bp_ready1", 64'(req1_ready), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_ready1", 64'(req1_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_idle_ready1", 64'(req1_ready), 64'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_rsp(id, res, lat);
    check("bp_next_id",  64'(id),  64'd1);
    check("bp_next_res", 64'(res), 64'd30);

    // Reset mid-multiply discards the job
    reset_dut();
    req0_valid = 1'b1; req0_a = 4'd7; req0_b = 4'd7;
    wait_hs(1'b0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    lc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) lc++;
    end
    check("rstmid_no_rsp", 64'(lc), 64'd0);
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd2;
    req1_valid = 1'b1; req1_a = 4'd3; req1_b = 4'd4;
    wait_rsp(id, res, lat);
    check("rstmid_id",  64'(id),  64'd0);
    check("rstmid_res", 64'(res), 64'd2);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Lone requester 1 streams at full rate despite the pointer
    reset_dut();
    req1_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req1_valid && req1_ready) hs_cyc.push_back(i);
      @(posedge clk); #1;
      req1_a = W'($urandom); req1_b = W'($urandom);
    end
    req1_valid = 1'b0;
    check("stream_count", 64'(hs_cyc.size() >= 6), 64'd1);
    for (int i = 1; i < hs_cyc.size(); i++)
      check("stream_gap", 64'(hs_cyc[i] - hs_cyc[i-1]), 64'(W + 2));

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst        = ($urandom_range(0, 199) == 0);
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_a     = W'($urandom); req0_b = W'($urandom);
      req1_a     = W'($urandom); req1_b = W'($urandom);
      rsp_ready  = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
